// File: rtl/core_demux_1to2_if.sv
// core_demux_1to2_if
//   Handshake bundle for the 1:2 stream demultiplexer.
//   Source side : i_valid, i_sel, i_data  -> o_ready
//   Sink 0 side : o_valid0, o_data0       <- i_ready0
//   Sink 1 side : o_valid1, o_data1       <- i_ready1
//   Status      : o_count (occupancy), o_cnt0/o_cnt1 (per-sink deliveries)
//   Signal names are taken from the demux's point of view (i_* enter it).
//   modport slave  : the demux itself
//   modport master : the environment (source + both sinks)
interface core_demux_1to2_if #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned DEPTH      = 2,
  parameter int unsigned CNT_WIDTH  = 16
);
  logic                       i_valid;
  logic                       i_sel;
  logic [DATA_WIDTH-1:0]      i_data;
  logic                       o_ready;
  logic                       o_valid0;
  logic [DATA_WIDTH-1:0]      o_data0;
  logic                       i_ready0;
  logic                       o_valid1;
  logic [DATA_WIDTH-1:0]      o_data1;
  logic                       i_ready1;
  logic [$clog2(DEPTH):0]     o_count;
  logic [CNT_WIDTH-1:0]       o_cnt0;
  logic [CNT_WIDTH-1:0]       o_cnt1;

  modport slave (
    input  i_valid, i_sel, i_data, i_ready0, i_ready1,
    output o_ready, o_valid0, o_data0, o_valid1, o_data1,
           o_count, o_cnt0, o_cnt1
  );

  modport master (
    output i_valid, i_sel, i_data, i_ready0, i_ready1,
    input  o_ready, o_valid0, o_data0, o_valid1, o_data1,
           o_count, o_cnt0, o_cnt1
  );
endinterface

// File: rtl/core_demux_1to2.sv
// core_demux_1to2
//   Buffered 1:2 stream demultiplexer. Each accepted transaction carries a
//   select bit that picks sink0 or sink1; transactions leave strictly in
//   order through a DEPTH-entry circular buffer, so a stalled head blocks
//   later entries for either sink. Per-sink delivery counters wrap freely.
//   Ports:
//     i_clk   : clock, rising edge
//     i_rst_n : asynchronous active-low reset
//     bus     : core_demux_1to2_if.slave handshake/status bundle
module core_demux_1to2 #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned DEPTH      = 2,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  core_demux_1to2_if.slave      bus
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned OCC_W = PTR_W + 1;
  localparam logic [OCC_W-1:0] DEPTH_C = OCC_W'(DEPTH);

  logic [DATA_WIDTH-1:0] mem_data [DEPTH];
  logic                  mem_sel  [DEPTH];

  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [OCC_W-1:0]      count;
  logic [CNT_WIDTH-1:0]  cnt0;
  logic [CNT_WIDTH-1:0]  cnt1;

  logic                  nonempty;
  logic                  head_sel;
  logic [DATA_WIDTH-1:0] head_data;
  logic                  ready;
  logic                  valid0;
  logic                  valid1;
  logic                  push;
  logic                  pop0;
  logic                  pop1;
  logic                  pop;

  // Full/empty come from occupancy, never from pointer equality. Gating
  // with i_rst_n holds o_ready low while reset is asserted even though
  // the occupancy is already zero.
  always_comb begin
    nonempty  = (count != '0);
    head_sel  = mem_sel[rd_ptr];
    head_data = mem_data[rd_ptr];
    ready     = i_rst_n & (count < DEPTH_C);
    valid0    = nonempty & ~head_sel;
    valid1    = nonempty &  head_sel;
    push      = bus.i_valid & ready;
    pop0      = valid0 & bus.i_ready0;
    pop1      = valid1 & bus.i_ready1;
    pop       = pop0 | pop1;
  end

  assign bus.o_ready  = ready;
  assign bus.o_valid0 = valid0;
  assign bus.o_valid1 = valid1;
  assign bus.o_data0  = valid0 ? head_data : '0;
  assign bus.o_data1  = valid1 ? head_data : '0;
  assign bus.o_count  = count;
  assign bus.o_cnt0   = cnt0;
  assign bus.o_cnt1   = cnt1;

  // Payload storage carries no reset.
  always_ff @(posedge i_clk) begin
    if (push) begin
      mem_data[wr_ptr] <= bus.i_data;
      mem_sel[wr_ptr]  <= bus.i_sel;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      cnt0   <= '0;
      cnt1   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (pop0) cnt0 <= cnt0 + 1'b1;
      if (pop1) cnt1 <= cnt1 + 1'b1;
    end
  end

endmodule

// File: doc/core_demux_1to2.md
Name: core_demux_1to2

Overview:
- Stream demultiplexer: steers each transaction from one valid/ready source to one of two sinks, chosen by a select bit captured with the transaction.
- Reverse of the 2:1 datapath select used in the core. Typical use: routing one core's memory requests to one of two targets, such as two cache banks or the instruction/data paths.
- Buffers up to DEPTH transactions and delivers them strictly in order.
- Keeps a per-sink delivered-transaction counter for debug and performance.

Parameters:
- DATA_WIDTH, 64: payload width in bits.
- DEPTH, 2: buffer entries. Must be a power of 2 and at least 2.
- CNT_WIDTH, 16: width of the per-sink delivery counters.

Ports:
- i_clk, input, 1: clock, rising edge.
- i_rst_n, input, 1: asynchronous active-low reset.
- i_valid, input, 1: source has a transaction.
- i_sel, input, 1: destination, 0 = sink0, 1 = sink1. Sampled with i_data.
- i_data, input, DATA_WIDTH: source payload.
- o_ready, output, 1: block can accept a transaction this cycle.
- o_valid0, output, 1: sink0 transaction valid.
- o_data0, output, DATA_WIDTH: sink0 payload.
- i_ready0, input, 1: sink0 accepts.
- o_valid1, output, 1: sink1 transaction valid.
- o_data1, output, DATA_WIDTH: sink1 payload.
- i_ready1, input, 1: sink1 accepts.
- o_count, output, $clog2(DEPTH)+1: buffer occupancy.
- o_cnt0, output, CNT_WIDTH: transactions delivered to sink0.
- o_cnt1, output, CNT_WIDTH: transactions delivered to sink1.

Behaviour:
- Reset (asynchronous, i_rst_n low):
  - Read pointer, write pointer and occupancy cleared.
  - o_valid0 = o_valid1 = 0, o_count = 0, o_cnt0 = o_cnt1 = 0.
  - o_ready = 0 while reset is asserted; o_ready = 1 in the first cycle after release.
  - Buffer contents need not be reset.
- Push:
  - o_ready = (o_count < DEPTH), combinational from occupancy only, never from i_ready*.
  - A transaction is accepted on a rising edge when i_valid & o_ready.
  - The entry {i_sel, i_data} is written at the write pointer; the write pointer advances modulo DEPTH.
- Head presentation:
  - When o_count > 0, the entry at the read pointer is the head.
  - o_valid0 = nonempty & ~head.sel; o_valid1 = nonempty & head.sel.
  - o_data0 = head.data when o_valid0, else 0. o_data1 likewise.
  - At most one of o_valid0/o_valid1 is high in any cycle.
- Pop:
  - The head is delivered on a rising edge when (o_valid0 & i_ready0) | (o_valid1 & i_ready1). The read pointer then advances.
  - The ready of the non-selected sink is ignored.
- Latency:
  - An accepted transaction is visible at the sink output no earlier than the next cycle.
  - There is no combinational input-to-output pass-through.
  - Minimum latency is 1 cycle.
- Ordering:
  - Strictly in order across both sinks.
  - A stalled head blocks later entries for the other sink (head-of-line blocking is intended).
- Occupancy:
  - Push and pop in the same cycle leaves o_count unchanged.
  - Push only: o_count + 1. Pop only: o_count - 1.
- Full: o_ready = 0, i_valid is ignored, and the data is not captured. A pop in the full cycle frees one entry, visible as o_ready = 1 next cycle.
- Empty: both o_valid* = 0 and i_ready* are ignored. A push while empty raises o_valid of the target sink next cycle.
- Pointer wrap: pointers are $clog2(DEPTH) bits and wrap naturally. Full and empty are derived from o_count, not from pointer equality.
- Counters: o_cnt0 increments on each sink0 pop, o_cnt1 on each sink1 pop. They wrap modulo 2^CNT_WIDTH with no saturation.
- Source protocol: the source must hold i_valid/i_sel/i_data stable until accepted. The block does not check this.
- Reset mid-operation: all buffered transactions are discarded, outputs go to their reset values immediately (asynchronously), and counters clear.

Test Plan:
- Reset, then push {sel=0, 0xAAAA} with i_ready0 = 1 -> o_valid0 = 1, o_data0 = 0xAAAA one cycle later, o_valid1 = 0, o_data1 = 0. Next cycle o_count = 0 and o_cnt0 = 1.
- Push sel = 1, 0, 1 (data 0x1, 0x2, 0x3) with both readies high -> deliveries in order: sink1 0x1, sink0 0x2, sink1 0x3. Final counters o_cnt0 = 1, o_cnt1 = 2.
- Hold i_ready0 = 0 and push {0, 0x10} then {1, 0x20} -> o_count = 2 and o_ready = 0. A third push is ignored. o_valid1 stays 0 until i_ready0 rises; then 0x10 and 0x20 deliver on consecutive cycles.
- Full buffer with head targeting sink1 and i_ready1 = 1, i_valid = 1 in the same cycle -> pop occurs, no push that cycle, o_count = 1. Push is accepted the following cycle.
- Hold push and pop every cycle for 10 transactions -> o_count stays at 1, pointers wrap without loss, and all 10 payloads arrive in order.
- Assert i_rst_n low mid-stream with o_count = 2 and o_cnt1 = 5 -> immediately o_valid* = 0, o_count = 0, o_cnt1 = 0. After release, o_ready = 1 and no stale data appears.
